sdp_rd_arbiter: RTL and testbench
=================================

Name: sdp_rd_arbiter

Overview:
- Shares the single read port (addrb/dob) of one simple-dual-port RAM block between two requesters.
- Each requester asks for a burst of consecutive RAM words.
- The block grants bursts round-robin, drives the RAM read address one word per cycle, and routes the returned words back to the owning requester with a last-beat flag.
- It sits between the read side of the AXI-written RAM and the consumers that scan its contents.

Parameters:
DW, 512, RAM word width in bits
DD, 16384, RAM depth in words; AW = clog2(DD)
RD_LAT, 2, RAM read latency in clocks from ram_addrb to valid ram_dob (1..4)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ram_addrb  out  AW  RAM read address (registered)
ram_dob  in  DW  RAM read data, valid RD_LAT clocks after ram_addrb
req_valid  in  2  burst request, bit i = requester i
req_ready  out  2  burst accept, bit i = requester i (combinational)
req_addr  in  2*AW  start word address; requester i uses bits [i*AW +: AW]
req_len  in  16  beats minus 1; requester i uses bits [i*8 +: 8]
rsp_valid  out  2  one-hot response strobe, bit i = word belongs to requester i
rsp_last  out  1  final beat of the burst
rsp_data  out  DW  response word (equals ram_dob)
busy  out  1  high in BURST state or while any read is in flight

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, ram_addrb=0, tag pipeline cleared, rsp_valid=0, rsp_last=0, busy=0. req_ready=0 while reset is high.
- rr_ptr names the requester with priority.
- IDLE state:
  - winner = rr_ptr if req_valid[rr_ptr], else the other requester if its req_valid is high, else none.
  - req_ready[winner]=1 combinationally; every other bit is 0. req_ready is never high outside IDLE.
  - Handshake (req_valid[i]&req_ready[i]) in cycle T: latch addr and len of requester i, owner=i, rr_ptr<=~i, go to BURST.
- BURST state, one beat per cycle:
  - Beat k (k=0..len) sets ram_addrb=(addr+k) mod DD at cycle T+1+k.
  - Address arithmetic is AW bits wide and wraps from DD-1 to 0. DD must be a power of 2.
  - Each beat pushes {valid=1, owner, last=(k==len)} into a RD_LAT-deep tag shift register.
  - The last beat returns to IDLE. New handshakes are possible in the next cycle, giving one dead cycle of ram_addrb between bursts.
  - ram_addrb holds its last value when idle.
- Response path:
  - The tag register output drives rsp_valid (one-hot by owner) and rsp_last.
  - rsp_data = ram_dob, combinational.
  - The first beat appears at T+1+RD_LAT. Beats are contiguous, len+1 cycles, and rsp_last is high only on the final one.
  - There is no backpressure: requesters must accept every rsp_valid beat.
- len=0 is a single-beat burst; rsp_last is asserted on its only beat. len=255 gives 256 beats.
- Both req_valid high in IDLE: rr_ptr wins. Strict alternation results while both keep requesting.
- Only one requester active: it is granted on every IDLE cycle, regardless of rr_ptr.
- A requester that drops req_valid before a handshake loses nothing; arbitration re-evaluates each IDLE cycle.
- req_addr and req_len changes after the handshake are ignored.
- Reset mid-burst or with reads in flight: all state and tags clear immediately. No further rsp_valid appears for the aborted burst.
- busy = (state==BURST) | any tag valid.

Test Plan:
1. DD=16, RD_LAT=2, mem[k]=k. Requester 0: addr=5, len=0, handshake at T -> ram_addrb=5 at T+1; at T+3 rsp_valid=01, rsp_last=1, rsp_data=5; busy low at T+4.
2. Requester 1: addr=14, len=3 -> ram_addrb 14,15,0,1 on consecutive cycles; rsp_valid=10 for 4 cycles, data 14,15,0,1; rsp_last only on data=1.
3. From reset, both req_valid high continuously, len=1 each -> grants in order 0,1,0,1. Each burst yields exactly 2 beats tagged to the correct requester. One idle ram_addrb cycle between bursts.
4. Requester 0 requests continuously; requester 1 raises req_valid mid-burst of requester 0 -> requester 1 gets the next grant; requester 0 is granted after it.
5. Requester 0: addr=0, len=7; assert reset at beat 3 for 1 cycle -> all outputs 0 in that cycle; no rsp_valid afterwards. A new request after reset completes normally.
6. Requester 0: len=255 from addr=0 -> exactly 256 contiguous responses, data 0..15 repeating; rsp_last only on beat 255.

Source files
------------

// File: rtl/sdp_rd_arbiter_if.sv
// ---------------------------------------------------------------------------
// sdp_rd_arbiter_if
// Bundles every non-clock signal of the shared RAM read-port arbiter.
//   ram_addrb  : RAM read address (driven by the arbiter)
//   ram_dob    : RAM read data, valid RD_LAT clocks after ram_addrb
//   req_valid  : burst request, bit i = requester i
//   req_ready  : burst accept, bit i = requester i
//   req_addr   : start word address, requester i in [i*AW +: AW]
//   req_len    : beats minus 1, requester i in [i*8 +: 8]
//   rsp_valid  : one-hot response strobe by owning requester
//   rsp_last   : final beat of the burst
//   rsp_data   : response word
//   busy       : burst in progress or reads in flight
// Modport master is the arbiter itself; slave is the surrounding RAM and
// requesters.
// ---------------------------------------------------------------------------
interface sdp_rd_arbiter_if #(
  parameter int DW = 512,
  parameter int AW = 14
);
  logic [AW-1:0]   ram_addrb;
  logic [DW-1:0]   ram_dob;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*AW-1:0] req_addr;
  logic [15:0]     req_len;
  logic [1:0]      rsp_valid;
  logic            rsp_last;
  logic [DW-1:0]   rsp_data;
  logic            busy;

  modport master (
    output ram_addrb, req_ready, rsp_valid, rsp_last, rsp_data, busy,
    input  ram_dob, req_valid, req_addr, req_len
  );

  modport slave (
    input  ram_addrb, req_ready, rsp_valid, rsp_last, rsp_data, busy,
    output ram_dob, req_valid, req_addr, req_len
  );
endinterface

// File: rtl/sdp_rd_arbiter.sv
// ---------------------------------------------------------------------------
// sdp_rd_arbiter
// Shares the single read port of a simple-dual-port RAM between two
// requesters. Bursts are granted round-robin; the RAM address advances one
// word per cycle and each returned word is steered back to its owner with a
// last-beat flag.
//
// Ports:
//   clk    : clock
//   reset  : asynchronous, active-high reset
//   bus    : sdp_rd_arbiter_if.master (RAM read port, request and
//            response channels, busy)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | arbitrating; req_ready may be raised for the winner
// S_BURST | issuing one RAM read address per cycle for the owner
// ---------------------------------------------------------------------------
module sdp_rd_arbiter #(
  parameter int DW     = 512,
  parameter int DD     = 16384,
  parameter int RD_LAT = 2
) (
  input logic             clk,
  input logic             reset,
  sdp_rd_arbiter_if.master bus
);

  localparam int AW = $clog2(DD);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_rr_ptr;
  logic            r_owner;
  logic [AW-1:0]   r_addrb;
  logic [7:0]      r_remain;

  // Tag pipeline: bit j of each vector is stage j; the oldest stage lines up
  // with the RAM data for the same beat.
  logic [RD_LAT-1:0] r_tag_vld;
  logic [RD_LAT-1:0] r_tag_own;
  logic [RD_LAT-1:0] r_tag_last;

  logic            w_gnt_any;
  logic            w_gnt_idx;
  logic            w_hs;
  logic [1:0]      w_req_ready;
  logic [AW-1:0]   w_sel_addr;
  logic [7:0]      w_sel_len;
  logic            w_beat_vld;
  logic            w_beat_last;
  logic [DW-1:0]   w_rsp_data;

  // Operand capture for whichever requester wins this cycle.
  assign w_sel_addr = w_gnt_idx ? bus.req_addr[2*AW-1:AW] : bus.req_addr[AW-1:0];
  assign w_sel_len  = w_gnt_idx ? bus.req_len[15:8]       : bus.req_len[7:0];
  assign w_hs       = |(w_req_ready & bus.req_valid);

  // ------------------------------------------------------------------------
  // Next-state, arbitration and beat generation
  // ------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_any   = 1'b0;
    w_gnt_idx   = r_rr_ptr;
    w_req_ready = 2'b00;
    w_beat_vld  = 1'b0;
    w_beat_last = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.req_valid[r_rr_ptr]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = r_rr_ptr;
        end else if (bus.req_valid[~r_rr_ptr]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = ~r_rr_ptr;
        end
        // Ready is held off while reset is asserted so no request can be
        // consumed by a block that is being cleared.
        if (w_gnt_any && !reset) begin
          w_req_ready[w_gnt_idx] = 1'b1;
          w_state_nxt            = S_BURST;
        end
      end

      S_BURST: begin
        w_beat_vld  = 1'b1;
        w_beat_last = (r_remain == 8'd0);
        if (w_beat_last) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // State, address and remaining-beat down-counter
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= 1'b0;
      r_owner  <= 1'b0;
      r_addrb  <= '0;
      r_remain <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) begin
        // Beat 0 address is presented the cycle after the handshake.
        r_addrb  <= w_sel_addr;
        r_remain <= w_sel_len;
        r_owner  <= w_gnt_idx;
        r_rr_ptr <= ~w_gnt_idx;
      end else if (w_beat_vld && !w_beat_last) begin
        // AW-bit add wraps DD-1 -> 0 because DD is a power of two.
        r_addrb  <= r_addrb + AW'(1);
        r_remain <= r_remain - 8'd1;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Tag shift register: one entry per issued address, RD_LAT deep, so the
  // output stage is valid in the same cycle as the matching ram_dob word.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag_vld  <= '0;
      r_tag_own  <= '0;
      r_tag_last <= '0;
    end else begin
      r_tag_vld[0]  <= w_beat_vld;
      r_tag_own[0]  <= r_owner;
      r_tag_last[0] <= w_beat_last;
      for (int j = 1; j < RD_LAT; j++) begin
        r_tag_vld[j]  <= r_tag_vld[j-1];
        r_tag_own[j]  <= r_tag_own[j-1];
        r_tag_last[j] <= r_tag_last[j-1];
      end
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign w_rsp_data    = bus.ram_dob;

  assign bus.ram_addrb = r_addrb;
  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = {r_tag_vld[RD_LAT-1] &  r_tag_own[RD_LAT-1],
                          r_tag_vld[RD_LAT-1] & ~r_tag_own[RD_LAT-1]};
  assign bus.rsp_last  = r_tag_vld[RD_LAT-1] & r_tag_last[RD_LAT-1];
  assign bus.rsp_data  = w_rsp_data;
  assign bus.busy      = (r_state == S_BURST) | (|r_tag_vld);

endmodule

// File: tb/tb_sdp_rd_arbiter.sv
module tb_sdp_rd_arbiter;
  localparam int DW     = 32;
  localparam int DD     = 16;
  localparam int AW     = 4;
  localparam int RD_LAT = 2;
  localparam int NRAND  = 800;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sdp_rd_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  sdp_rd_arbiter #(.DW(DW), .DD(DD), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAM model: mem[k] = k, read latency RD_LAT
  logic [DW-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    pipe[0] <= DW'(bus.ram_addrb);
    for (int j = 1; j < RD_LAT; j++) pipe[j] <= pipe[j-1];
  end
  assign bus.ram_dob = pipe[RD_LAT-1];

  typedef struct {
    logic [1:0]    rv;
    logic [DW-1:0] data;
    logic          last;
    int            t;
  } beat_t;

  typedef struct {
    int who;
    int addr;
    int len;
    int exp_beats;
    int exp_first;
    int exp_last;
  } vec_t;

  int    errs   = 0;
  int    checks = 0;
  int    ncyc   = 0;
  beat_t log_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    ncyc++;
    if (bus.rsp_valid != 2'b00)
      log_q.push_back('{rv: bus.rsp_valid, data: bus.rsp_data, last: bus.rsp_last, t: ncyc});
  endtask

  task automatic set_req(input int i, input logic v, input int a, input int l);
    bus.req_valid[i]         = v;
    bus.req_addr[i*AW +: AW] = AW'(a);
    bus.req_len[i*8 +: 8]    = 8'(l);
  endtask

  task automatic do_reset();
    tick();
    reset         = 1'b1;
    bus.req_valid = 2'b00;
    tick();
    reset = 1'b0;
  endtask

  task automatic run_burst(input vec_t v);
    int t0, waited;
    logic [1:0] oh;
    oh = (v.who == 1) ? 2'b10 : 2'b01;
    log_q.delete();
    tick();
    bus.req_valid = 2'b00;
    set_req(v.who, 1'b1, v.addr, v.len);
    #1;
    waited = 0;
    while (bus.req_ready[v.who] !== 1'b1 && waited < 20) begin
      tick();
      #1;
      waited++;
    end
    chk("grant_latency", waited, 0);
    if (waited >= 20) return;
    t0 = ncyc;
    for (int i = 1; i <= v.len + RD_LAT + 3; i++) begin
      tick();
      if (i == 1) begin
        set_req(v.who, 1'b0, v.addr + 7, v.len + 3);
        chk("busy_in_burst", bus.busy, 1);
        #1;
        chk("ready_in_burst", bus.req_ready, 2'b00);
      end
      if (i <= v.len + 1) chk("burst_addrb", bus.ram_addrb, (v.addr + i - 1) % DD);
      else                chk("hold_addrb", bus.ram_addrb, (v.addr + v.len) % DD);
      if (i == v.len + 1 + RD_LAT) chk("busy_last_beat", bus.busy, 1);
      if (i == v.len + 2 + RD_LAT) chk("busy_drop", bus.busy, 0);
    end
    chk("beat_count", log_q.size(), v.exp_beats);
    if (log_q.size() > 0) begin
      chk("first_data", log_q[0].data, v.exp_first);
      chk("last_data", log_q[log_q.size()-1].data, v.exp_last);
    end
    foreach (log_q[b]) begin
      chk("rsp_owner", log_q[b].rv, oh);
      chk("rsp_data", log_q[b].data, (v.addr + b) % DD);
      chk("rsp_last", log_q[b].last, b == v.len);
      chk("rsp_time", log_q[b].t, t0 + 1 + RD_LAT + b);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   gw[$];
    int   gc[$];
    int   i0;
    int   e3_who[4];
    int   e3_cyc[4];
    int   e3_ab[12];
    int   e3_dat[8];
    int   e3_t[8];
    int   e4_who[4];
    int   e4_cyc[4];

    vecs[0] = '{0, 5, 0, 1, 5, 5};
    vecs[1] = '{1, 14, 3, 4, 14, 1};
    vecs[2] = '{0, 15, 0, 1, 15, 15};
    vecs[3] = '{1, 0, 15, 16, 0, 15};
    vecs[4] = '{0, 9, 8, 9, 9, 1};
    vecs[5] = '{1, 6, 2, 3, 6, 8};

    reset         = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_addr  = '0;
    bus.req_len   = '0;

    // reset state, with both requests raised to see ready gated
    #12;
    bus.req_valid = 2'b11;
    #1;
    chk("rst_ready", bus.req_ready, 2'b00);
    chk("rst_addrb", bus.ram_addrb, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
    chk("rst_rsp_last", bus.rsp_last, 0);
    chk("rst_busy", bus.busy, 0);
    bus.req_valid = 2'b00;
    tick();
    reset = 1'b0;

    // table of single bursts
    foreach (vecs[k]) run_burst(vecs[k]);

    // both requesting continuously, len=1 each: strict alternation
    do_reset();
    log_q.delete();
    gw.delete();
    gc.delete();
    e3_who = '{0, 1, 0, 1};
    e3_cyc = '{0, 3, 6, 9};
    e3_ab  = '{0, 2, 3, 3, 9, 10, 10, 2, 3, 3, 9, 10};
    e3_dat = '{2, 3, 9, 10, 2, 3, 9, 10};
    e3_t   = '{3, 4, 6, 7, 9, 10, 12, 13};
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) begin
        i0 = ncyc;
        set_req(0, 1'b1, 2, 1);
        set_req(1, 1'b1, 9, 1);
      end
      chk("alt_addrb", bus.ram_addrb, e3_ab[i]);
      #1;
      for (int k = 0; k < 2; k++)
        if (bus.req_valid[k] && bus.req_ready[k]) begin gw.push_back(k); gc.push_back(i); end
    end
    tick();
    bus.req_valid = 2'b00;
    for (int i = 0; i < 6; i++) tick();
    chk("alt_grant_count", gw.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < gw.size()) begin
        chk("alt_grant_who", gw[k], e3_who[k]);
        chk("alt_grant_cyc", gc[k], e3_cyc[k]);
      end
    chk("alt_beat_count", log_q.size(), 8);
    foreach (log_q[b])
      if (b < 8) begin
        chk("alt_owner", log_q[b].rv, ((b / 2) % 2 == 1) ? 2'b10 : 2'b01);
        chk("alt_data", log_q[b].data, e3_dat[b]);
        chk("alt_last", log_q[b].last, b % 2 == 1);
        chk("alt_time", log_q[b].t - i0, e3_t[b]);
      end

    // requester 1 arrives mid-burst of requester 0
    do_reset();
    gw.delete();
    gc.delete();
    e4_who = '{0, 1, 0, 0};
    e4_cyc = '{0, 5, 7, 12};
    for (int i = 0; i < 13; i++) begin
      tick();
      if (i == 0) set_req(0, 1'b1, 0, 3);
      if (i == 2) set_req(1, 1'b1, 8, 0);
      if (i == 6) set_req(1, 1'b0, 8, 0);
      #1;
      for (int k = 0; k < 2; k++)
        if (bus.req_valid[k] && bus.req_ready[k]) begin gw.push_back(k); gc.push_back(i); end
    end
    tick();
    bus.req_valid = 2'b00;
    for (int i = 0; i < 10; i++) tick();
    chk("late_grant_count", gw.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < gw.size()) begin
        chk("late_grant_who", gw[k], e4_who[k]);
        chk("late_grant_cyc", gc[k], e4_cyc[k]);
      end

    // reset during beat 3 of an 8-beat burst
    do_reset();
    tick();
    set_req(0, 1'b1, 0, 7);
    #1;
    chk("abort_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    tick();
    tick();
    tick();
    chk("abort_beat3_addrb", bus.ram_addrb, 3);
    reset = 1'b1;
    set_req(1, 1'b1, 4, 0);
    #1;
    chk("abort_addrb", bus.ram_addrb, 0);
    chk("abort_rsp_valid", bus.rsp_valid, 2'b00);
    chk("abort_rsp_last", bus.rsp_last, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_ready_gated", bus.req_ready, 2'b00);
    log_q.delete();
    tick();
    bus.req_valid = 2'b00;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("abort_no_rsp", log_q.size(), 0);
    chk("abort_idle_busy", bus.busy, 0);
    run_burst('{0, 3, 2, 3, 3, 5});

    // maximum length burst
    do_reset();
    run_burst('{0, 0, 255, 256, 0, 15});

    // randomized traffic against a transaction-level model
    do_reset();
    begin
      logic [1:0] exp_rv [int];
      logic       exp_ls [int];
      int         exp_dt [int];
      int         exp_ab [int];
      bit         exp_bz [int];
      int         free_at, pr, w, cur_ab;
      logic [1:0] vv, exp_rdy;
      int         aa [2];
      int         ll [2];
      free_at = 0;
      pr      = 0;
      cur_ab  = 0;
      for (int c = 0; c < NRAND + RD_LAT + 12; c++) begin
        tick();
        if (exp_ab.exists(c)) cur_ab = exp_ab[c];
        chk("rnd_addrb", bus.ram_addrb, cur_ab);
        chk("rnd_busy", bus.busy, exp_bz.exists(c));
        if (exp_rv.exists(c)) begin
          chk("rnd_rsp_valid", bus.rsp_valid, exp_rv[c]);
          chk("rnd_rsp_last", bus.rsp_last, exp_ls[c]);
          chk("rnd_rsp_data", bus.rsp_data, exp_dt[c]);
        end else begin
          chk("rnd_rsp_quiet", bus.rsp_valid, 2'b00);
        end
        for (int k = 0; k < 2; k++) begin
          vv[k] = (c < NRAND) ? 1'($urandom_range(0, 1)) : 1'b0;
          aa[k] = $urandom_range(0, DD - 1);
          ll[k] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 5);
          set_req(k, vv[k], aa[k], ll[k]);
        end
        #1;
        w       = -1;
        exp_rdy = 2'b00;
        if (c >= free_at) begin
          if (vv[pr])            w = pr;
          else if (vv[1 - pr])   w = 1 - pr;
        end
        if (w >= 0) exp_rdy[w] = 1'b1;
        chk("rnd_ready", bus.req_ready, exp_rdy);
        if (w >= 0) begin
          for (int k = 0; k <= ll[w]; k++) begin
            exp_ab[c + 1 + k]          = (aa[w] + k) % DD;
            exp_rv[c + 1 + RD_LAT + k] = (w == 1) ? 2'b10 : 2'b01;
            exp_ls[c + 1 + RD_LAT + k] = (k == ll[w]);
            exp_dt[c + 1 + RD_LAT + k] = (aa[w] + k) % DD;
            for (int d = 0; d <= RD_LAT; d++) exp_bz[c + 1 + k + d] = 1'b1;
          end
          free_at = c + ll[w] + 2;
          pr      = 1 - w;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
